// File: rtl/dram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dram_arbiter_pkg
// Configuration and shared types for the data-RAM arbiter.
//   dram_depth       : word-address width of the data RAM (2**dram_depth words)
//   dram_arb_state_e : access sequencer states
//   dram_arb_req_t   : one requester's address / write data / byte strobes
// Optional feature macro used by the arbiter: DRAM_ARB_RR_EN (round-robin).
// -----------------------------------------------------------------------------
package dram_arbiter_pkg;

  localparam int dram_depth = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } dram_arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dram_arb_req_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_arbiter_if
// Bundles the two requester buses (port 0 = instruction fetch, port 1 =
// load/store) and the data-RAM port driven by the arbiter.
//   p_valid/p_addr/p_wdata/p_wstrb : requests, held stable until p_ready
//   p_rdata/p_ready                : completion data and one-cycle pulse
//   dram_*                         : RAM write/read port (1-cycle read latency)
// Modports: master = requesters, slave = arbiter, ram = the RAM macro.
// -----------------------------------------------------------------------------
interface dram_arbiter_if
  import dram_arbiter_pkg::*;
#(
  parameter int DEPTH = dram_depth
);

  logic [1:0]        p_valid;
  logic [1:0][31:0]  p_addr;
  logic [1:0][31:0]  p_wdata;
  logic [1:0][3:0]   p_wstrb;
  logic [1:0][31:0]  p_rdata;
  logic [1:0]        p_ready;

  logic              dram_wen;
  logic [DEPTH-1:0]  dram_waddr;
  logic [DEPTH-1:0]  dram_raddr;
  logic [31:0]       dram_wdata;
  logic [3:0]        dram_wstrb;
  logic [31:0]       dram_rdata;

  modport master (
    output p_valid, p_addr, p_wdata, p_wstrb,
    input  p_rdata, p_ready
  );

  modport slave (
    input  p_valid, p_addr, p_wdata, p_wstrb,
    output p_rdata, p_ready,
    output dram_wen, dram_waddr, dram_raddr, dram_wdata, dram_wstrb,
    input  dram_rdata
  );

  modport ram (
    input  dram_wen, dram_waddr, dram_raddr, dram_wdata, dram_wstrb,
    output dram_rdata
  );

endinterface

// File: rtl/dram_arb_pick.sv
// -----------------------------------------------------------------------------
// dram_arb_pick
// Combinational winner select between the two request ports.
//   valid_i     : per-port request valid
//   last_i      : last granted port (only with DRAM_ARB_RR_EN)
//   grant_o     : winning port id (meaningful only when any_valid_o)
//   any_valid_o : at least one port is requesting
// Default: port 1 has fixed priority. With DRAM_ARB_RR_EN defined, a tie
// goes to the port that did not win last; a lone requester always wins.
// -----------------------------------------------------------------------------
module dram_arb_pick (
  input  logic [1:0] valid_i,
`ifdef DRAM_ARB_RR_EN
  input  logic       last_i,
`endif
  output logic       grant_o,
  output logic       any_valid_o
);

  assign any_valid_o = |valid_i;

`ifdef DRAM_ARB_RR_EN
  assign grant_o = (&valid_i) ? ~last_i : valid_i[1];
`else
  assign grant_o = valid_i[1];
`endif

endmodule

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
// Shares the data RAM between the instruction-fetch bus (port 0) and the
// load/store bus (port 1). One request is in flight at a time:
//   IDLE -> ACCESS -> WAIT -> DONE -> IDLE
// so a request seen in IDLE at cycle t completes with p_ready at t+3.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dram_arbiter_if.slave (requester buses + RAM port)
// Byte addresses map to word index addr[DEPTH+1:2]; other address bits are
// ignored, so addresses alias. Writes (wstrb != 0) leave p_rdata unchanged.
// Optional macro DRAM_ARB_RR_EN selects round-robin arbitration instead of
// fixed priority to port 1.
// -----------------------------------------------------------------------------
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int DEPTH = dram_depth
)(
  input logic           clk,
  input logic           rst_n,
  dram_arbiter_if.slave bus
);

  dram_arb_state_e  state_q, state_d;
  logic             id_q, id_d;
  logic [DEPTH-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [1:0]       ready_q, ready_d;

  logic             grant;
  logic             any_valid;
  dram_arb_req_t    win_req;
  logic             unused_addr_bits;

`ifdef DRAM_ARB_RR_EN
  logic             last_q, last_d;
`endif

  dram_arb_pick u_pick (
    .valid_i     (bus.p_valid),
`ifdef DRAM_ARB_RR_EN
    .last_i      (last_q),
`endif
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );

  always_comb begin
    win_req = '{addr:  bus.p_addr[grant],
                wdata: bus.p_wdata[grant],
                wstrb: bus.p_wstrb[grant]};
  end

  // Byte-lane and above-RAM address bits are deliberately dropped (aliasing).
  assign unused_addr_bits = ^{win_req.addr[31:DEPTH+2], win_req.addr[1:0]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    id_d    = id_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    ready_d = '0;
`ifdef DRAM_ARB_RR_EN
    last_d  = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          id_d    = grant;
          idx_d   = win_req.addr[DEPTH+1:2];
          wdata_d = win_req.wdata;
          wstrb_d = win_req.wstrb;
`ifdef DRAM_ARB_RR_EN
          last_d  = grant;
`endif
          state_d = ACCESS;
        end
      end
      // RAM sees the registered index this cycle; a write commits at its end.
      ACCESS: state_d = WAIT;
      WAIT: begin
        if (wstrb_q == 4'b0000) rdata_d[id_q] = bus.dram_rdata;
        ready_d[id_q] = 1'b1;
        state_d       = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      ready_q <= '0;
`ifdef DRAM_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the same
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
`ifdef DRAM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Write enable decodes straight from the state flop, so an asynchronous
  // reset in ACCESS drops it at once and the write never commits.
  assign bus.dram_wen   = (state_q == ACCESS) && (wstrb_q != 4'b0000);
  assign bus.dram_waddr = idx_q;
  assign bus.dram_raddr = idx_q;
  assign bus.dram_wdata = wdata_q;
  assign bus.dram_wstrb = wstrb_q;

  assign bus.p_rdata = rdata_q;
  assign bus.p_ready = ready_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
// Self-checking bench for dram_arbiter with a behavioural data RAM attached.
// Directed vectors, contention and reset-in-ACCESS sequences, then random
// two-port traffic compared against a word-array reference model.
// Build with +define+DRAM_ARB_RR_EN to exercise the round-robin variant.
// -----------------------------------------------------------------------------
module tb_dram_arbiter;
  import dram_arbiter_pkg::*;

  localparam int DEPTH    = 10;
  localparam int N_RAND   = 5000;   // requests per port in the random phase

  logic clk;
  logic rst_n;

  dram_arbiter_if #(.DEPTH(DEPTH)) bus ();

  dram_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with a backdoor write port for preloading.
  logic [31:0]      ram [1024];
  logic             bd_we;
  logic [DEPTH-1:0] bd_addr;
  logic [31:0]      bd_data;

  always @(posedge clk) begin
    if (bus.dram_wen) begin
      for (int b = 0; b < 4; b++)
        if (bus.dram_wstrb[b]) ram[bus.dram_waddr][8*b +: 8] <= bus.dram_wdata[8*b +: 8];
    end
    if (bd_we) ram[bd_addr] <= bd_data;
    bus.dram_rdata <= ram[bus.dram_raddr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic bd_write(input int idx, input logic [31:0] data);
    bd_addr = idx[DEPTH-1:0];
    bd_data = data;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we   = 1'b0;
  endtask

  task automatic do_reset();
    bus.p_valid = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int               port;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic [31:0]      exp_rdata;
    logic [DEPTH-1:0] exp_idx;
  } vec_t;

  // Single-port transaction started in IDLE; checks latency, RAM port and data.
  task automatic do_txn(input vec_t v, input string tag);
    int               lat;
    logic             wen_seen;
    logic [DEPTH-1:0] idx_seen;
    bus.p_addr[v.port]  = v.addr;
    bus.p_wdata[v.port] = v.wdata;
    bus.p_wstrb[v.port] = v.wstrb;
    bus.p_valid[v.port] = 1'b1;
    lat      = 0;
    wen_seen = 1'b0;
    idx_seen = '0;
    while (!bus.p_ready[v.port] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        wen_seen = bus.dram_wen;
        idx_seen = bus.dram_waddr;
      end
    end
    check($sformatf("%s latency", tag), lat, 3);
    check($sformatf("%s dram_wen", tag), {31'b0, wen_seen}, {31'b0, v.wstrb != 4'b0000});
    check($sformatf("%s word index", tag), {22'b0, idx_seen}, {22'b0, v.exp_idx});
    check($sformatf("%s rdata", tag), bus.p_rdata[v.port], v.exp_rdata);
    check($sformatf("%s other ready", tag), {31'b0, bus.p_ready[1 - v.port]}, 32'd0);
    @(posedge clk); #1;
    bus.p_valid[v.port] = 1'b0;
  endtask

  // Both ports read in the same IDLE: port 0 word 5, port 1 word 8.
  task automatic contend(input int exp_lat0, input int exp_lat1, input string tag);
    int          lat  [2];
    logic        drop [2];
    logic [31:0] rd   [2];
    lat  = '{0, 0};
    drop = '{1'b0, 1'b0};
    rd   = '{32'd0, 32'd0};
    bus.p_addr[0]  = 32'h14;
    bus.p_addr[1]  = 32'h20;
    bus.p_wstrb    = '0;
    bus.p_valid    = 2'b11;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++)
        if (drop[k]) begin
          bus.p_valid[k] = 1'b0;
          drop[k] = 1'b0;
        end
      for (int k = 0; k < 2; k++)
        if (bus.p_ready[k] && lat[k] == 0) begin
          lat[k]  = n;
          rd[k]   = bus.p_rdata[k];
          drop[k] = 1'b1;
        end
      if (lat[0] != 0 && lat[1] != 0 && !drop[0] && !drop[1]) break;
    end
    bus.p_valid = 2'b00;
    check($sformatf("%s port0 done cycle", tag), lat[0], exp_lat0);
    check($sformatf("%s port1 done cycle", tag), lat[1], exp_lat1);
    check($sformatf("%s port0 data", tag), rd[0], 32'h77ADBEEF);
    check($sformatf("%s port1 data", tag), rd[1], 32'h00220044);
  endtask

  // Random-phase reference state: word array plus each port's last read data.
  logic [31:0] ref_mem  [1024];
  logic [31:0] ref_last [2];
  int          done_cnt [2];
  int          ready_cnt[2];
  logic        stop;

  task automatic rand_port(input int p);
    logic [31:0] a, wd, exp;
    logic [3:0]  ws;
    int          gap, waited, idx;
    for (int r = 0; r < N_RAND; r++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if (gap != 0) begin
        bus.p_valid[p] = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      a  = $urandom & 32'hFFFF_F03F;   // 16 hot words, random aliasing bits
      wd = $urandom;
      ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      bus.p_addr[p]  = a;
      bus.p_wdata[p] = wd;
      bus.p_wstrb[p] = ws;
      bus.p_valid[p] = 1'b1;
      waited = 0;
      while (!bus.p_ready[p] && waited < 300) begin
        @(posedge clk); #1;
        waited++;
      end
      if (!bus.p_ready[p]) begin
        check($sformatf("rand port%0d ready within bound", p), waited, 0);
        bus.p_valid[p] = 1'b0;
        return;
      end
      idx = int'((a >> 2) & 32'h3FF);
      if (ws == 4'h0) begin
        ref_last[p] = ref_mem[idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (ws[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
      exp = ref_last[p];
      check($sformatf("rand port%0d req%0d data", p, r), bus.p_rdata[p], exp);
      done_cnt[p]++;
      @(posedge clk); #1;
    end
    bus.p_valid[p] = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.p_valid = '0;
    bus.p_addr  = '0;
    bus.p_wdata = '0;
    bus.p_wstrb = '0;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    stop    = 1'b0;
    rst_n   = 1'b0;

    bd_write(5,    32'hDEADBEEF);
    bd_write(8,    32'h0);
    bd_write(9,    32'hCAFEF00D);
    bd_write(1021, 32'h0);
    do_reset();

    check("reset p_ready", {30'b0, bus.p_ready}, 32'd0);
    check("reset p_rdata0", bus.p_rdata[0], 32'd0);
    check("reset p_rdata1", bus.p_rdata[1], 32'd0);
    check("reset dram_wen", {31'b0, bus.dram_wen}, 32'd0);

    // port, addr, wdata, wstrb, expected rdata, expected word index
    vecs[0] = '{0, 32'h0000_0014, 32'h0,         4'b0000, 32'hDEADBEEF, 10'd5};
    vecs[1] = '{1, 32'h0000_0020, 32'h11223344,  4'b0101, 32'h00000000, 10'd8};
    vecs[2] = '{0, 32'h0000_0020, 32'h0,         4'b0000, 32'h00220044, 10'd8};
    vecs[3] = '{0, 32'hFFFF_FFF7, 32'hA5A55A5A,  4'b1111, 32'h00220044, 10'd1021};
    vecs[4] = '{1, 32'h0000_0FF4, 32'h0,         4'b0000, 32'hA5A55A5A, 10'd1021};
    vecs[5] = '{1, 32'h1234_5015, 32'h0,         4'b0000, 32'hDEADBEEF, 10'd5};
    vecs[6] = '{1, 32'h0000_0014, 32'h77000000,  4'b1000, 32'hDEADBEEF, 10'd5};
    vecs[7] = '{0, 32'h0000_0017, 32'h0,         4'b0000, 32'h77ADBEEF, 10'd5};
    for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Contention: fresh reset so the round-robin pointer starts at 0.
    do_reset();
    contend(7, 3, "contend A");
    contend(7, 3, "contend B");
    do_txn('{1, 32'h20, 32'h0, 4'b0000, 32'h00220044, 10'd8}, "solo p1");
`ifdef DRAM_ARB_RR_EN
    contend(3, 7, "contend after p1");
`else
    contend(7, 3, "contend after p1");
`endif

    // Reset asserted in the ACCESS cycle of a port-1 write to word 9.
    bus.p_addr[1]  = 32'h24;
    bus.p_wdata[1] = 32'h12345678;
    bus.p_wstrb[1] = 4'b1111;
    bus.p_valid[1] = 1'b1;
    @(posedge clk); #1;
    check("access wen before reset", {31'b0, bus.dram_wen}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("wen falls on async reset", {31'b0, bus.dram_wen}, 32'd0);
    check("ready cleared by reset", {30'b0, bus.p_ready}, 32'd0);
    check("rdata0 cleared by reset", bus.p_rdata[0], 32'd0);
    check("rdata1 cleared by reset", bus.p_rdata[1], 32'd0);
    bus.p_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("word 9 not written", ram[9], 32'hCAFEF00D);
    @(posedge clk); #1;
    check("no ready after reset", {30'b0, bus.p_ready}, 32'd0);
    do_txn('{1, 32'h24, 32'h12345678, 4'b1111, 32'h0,         10'd9}, "reissue write");
    do_txn('{0, 32'h24, 32'h0,         4'b0000, 32'h12345678, 10'd9}, "reissue readback");

    // Random traffic against the reference model.
    for (int i = 0; i < 16; i++) begin
      bd_write(i, 32'h0);
      ref_mem[i] = 32'h0;
    end
    do_reset();
    ref_last  = '{32'h0, 32'h0};
    done_cnt  = '{0, 0};
    ready_cnt = '{0, 0};
    fork
      begin
        fork
          rand_port(0);
          rand_port(1);
        join
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(negedge clk);
          if (|bus.p_ready) begin
            check("single ready per cycle", $countones(bus.p_ready), 1);
            for (int k = 0; k < 2; k++)
              if (bus.p_ready[k]) ready_cnt[k]++;
          end
        end
      end
    join
    check("rand port0 requests completed", done_cnt[0], N_RAND);
    check("rand port1 requests completed", done_cnt[1], N_RAND);
    check("rand port0 one ready per request", ready_cnt[0], done_cnt[0]);
    check("rand port1 one ready per request", ready_cnt[1], done_cnt[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
